bus_cycle_ctrl: RTL
===================

# bus_cycle_ctrl

Bus cycle controller sitting directly downstream of the bus arbiter. It latches the one-hot grant `BAGD`, runs the address phase and a counted data burst against the shared target using the `AddressValid` / `TargetReady` / `DataStrobe` handshake, then pulses a per-device completion so the master drops its `BARQ`. Target stalls and grant loss are covered by a watchdog that reports them on `Error`.

## Interface
- `DeviceMaxNumber`, 4, number of masters; width of grant and completion vectors.
- `LenWidth`, 4, width of each per-device burst-length field; a burst has `XferLen+1` beats.
- `TimeoutCycles`, 16, consecutive cycles with `TargetReady` low before abort; must be ≥2.
- `clk`  in  1  single clock; all logic is on the rising edge.
- `Reset`  in  1  synchronous, active-high reset.
- `BAGD`  in  DeviceMaxNumber  one-hot grant from the arbiter.
- `XferLen`  in  DeviceMaxNumber*LenWidth  per-device burst length; device i uses bits [i*LenWidth +: LenWidth].
- `TargetReady`  in  1  target accepts the current address or data beat.
- `AddressValid`  out  1  address phase active.
- `DataStrobe`  out  1  data beat presented this cycle.
- `Done`  out  DeviceMaxNumber  one-cycle pulse on the owning device's bit when its cycle ends, on success or abort.
- `ActiveDev`  out  $clog2(DeviceMaxNumber)  index of the latched owner; valid while not IDLE.
- `Error`  out  1  one-cycle pulse on abort (timeout, grant loss, or multi-hot grant).

## Operation
- Reset: state IDLE. All outputs are 0: `AddressValid`, `DataStrobe`, `Done`, `ActiveDev`, `Error`. Beat counter and watchdog are cleared.
- Reset asserted mid-cycle forces IDLE on the next edge. No `Done` or `Error` pulse is issued for the killed cycle.
- **IDLE**
  - `BAGD` one-hot: latch the owner index and `XferLen`, then go to ADDR.
  - `BAGD` zero: stay in IDLE.
  - `BAGD` multi-hot: pulse `Error`, no `Done`, stay in IDLE.
- **ADDR**
  - `AddressValid`=1.
  - `TargetReady`=1: go to DATA. The beat counter loads the latched length.
- **DATA**
  - `DataStrobe`=1 while presenting a beat.
  - Each cycle with `TargetReady`=1 consumes one beat.
  - Last beat accepted (counter==0): go to DONE. Otherwise decrement the counter.
- **DONE**
  - `Done[owner]`=1 for exactly one cycle, then IDLE.
- **ERR**
  - `Error`=1 and `Done[owner]`=1 for one cycle, then IDLE.
- Watchdog
  - Counts consecutive ADDR/DATA cycles with `TargetReady`=0. It clears on any accepted handshake and on every state entry.
  - Reaching `TimeoutCycles` goes to ERR.
- Grant loss: in ADDR or DATA, `BAGD[owner]`=0 goes to ERR on the next edge. Grant loss has priority over a simultaneous `TargetReady`, so the beat is not counted.
- The latched length ignores `XferLen` changes after latching.
- The counter is `LenWidth` bits wide with no wrap: `XferLen`=all-ones gives 2^LenWidth beats.

## Timing
- All outputs are registered, decoded from the state register.
- Grant seen at edge t (one-hot): `AddressValid` high from cycle t+1.
- Address accepted at edge a: `DataStrobe` high from a+1.
- Zero-wait target: N+1 beats take N+1 cycles of `DataStrobe`. `Done` follows in the cycle after the last beat.
- Minimum cycle, `XferLen`=0 with `TargetReady` held high, measured from the IDLE cycle that samples `BAGD`:
  - cycle t+1: ADDR
  - cycle t+2: DATA
  - cycle t+3: DONE
  - cycle t+4: IDLE, able to accept a new grant
- The arbiter must hold `BAGD` until `Done`. The master must drop `BARQ` no later than the cycle after `Done`.
- Timeout: `Error` rises `TimeoutCycles`+1 cycles after the first stalled cycle.

## Structure
- A shared package `bus_pkg` holds:
  - `bus_state_t` enum: IDLE, ADDR, DATA, DONE, ERR.
  - default `DeviceMaxNumber` and `LenWidth` constants.
  - a `onehot_to_idx` function, also usable by the arbiter.
- One sub-module, `bus_watchdog`: a stall counter with `clr`, `stall`, and `expired` ports, parameterised by `TimeoutCycles`.

## Test plan
- Reset, then `BAGD`=4'b0010, `XferLen[1]`=3, `TargetReady` held 1 → `AddressValid` for 1 cycle, `DataStrobe` for 4 cycles, `Done`=4'b0010 for 1 cycle, `ActiveDev`=1, `Error` never set.
- `BAGD`=4'b1000, `TargetReady` toggling 1,0,1,0 during DATA with `XferLen`=1 → exactly 2 beats accepted, `Done[3]` pulses once.
- `BAGD`=4'b0001, `TargetReady` held 0 → `AddressValid` held for 17 cycles, then `Error` and `Done[0]` pulse together, return to IDLE.
- `BAGD` drops to 0 in the second DATA beat with `TargetReady`=1 → that beat is not counted, `Error` and `Done[owner]` pulse on the next cycle.
- `BAGD`=4'b0110 in IDLE → `Error` pulses for 1 cycle, `Done` stays 0, `AddressValid` stays 0.
- `Reset` asserted during DATA → all outputs 0 on the next cycle, no `Done`; a new grant afterwards starts a clean cycle with the full beat count.

Source files
------------

// File: rtl/bus_pkg.sv
// Shared bus types and helpers for the cycle controller
// and the arbiter that feeds it.
package bus_pkg;

  localparam int DEV_MAX = 4;
  localparam int LEN_W   = 4;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    ADDR = 3'd1,
    DATA = 3'd2,
    DONE = 3'd3,
    ERR  = 3'd4
  } bus_state_t;

  function automatic logic [7:0] onehot_to_idx(
    input logic [31:0] oh
  );
    logic [7:0] idx;
    idx = '0;
    for (int i = 0; i < 32; i++)
      if (oh[i]) idx = 8'(i);
    return idx;
  endfunction

endpackage

// File: rtl/bus_cycle_ctrl_watchdog.sv
// Stall counter: counts consecutive stalled cycles
// and flags expiry once TimeoutCycles is reached.
module bus_watchdog #(
  parameter int TimeoutCycles = 16
) (
  input  logic clk,
  input  logic Reset,
  input  logic clr,
  input  logic stall,
  output logic expired
);

  localparam int CW = $clog2(TimeoutCycles + 1);

  logic [CW-1:0] r_cnt;

  assign expired = (r_cnt == CW'(TimeoutCycles));

  always_ff @(posedge clk) begin
    if (Reset || clr)
      r_cnt <= '0;
    else if (stall && !expired)
      r_cnt <= r_cnt + 1'b1;
  end

endmodule

// File: rtl/bus_cycle_ctrl.sv
// Bus cycle controller: latches the arbiter grant, runs
// address phase plus counted burst, reports done/abort.
module bus_cycle_ctrl
  import bus_pkg::*;
#(
  parameter int DeviceMaxNumber = DEV_MAX,
  parameter int LenWidth        = LEN_W,
  parameter int TimeoutCycles   = 16
) (
  input  logic                           clk,
  input  logic                           Reset,
  input  logic [DeviceMaxNumber-1:0]     BAGD,
  input  logic [DeviceMaxNumber*LenWidth-1:0] XferLen,
  input  logic                           TargetReady,
  output logic                           AddressValid,
  output logic                           DataStrobe,
  output logic [DeviceMaxNumber-1:0]     Done,
  output logic [$clog2(DeviceMaxNumber)-1:0] ActiveDev,
  output logic                           Error
);

  localparam int IW = $clog2(DeviceMaxNumber);

  bus_state_t          r_state;
  bus_state_t          w_next;
  logic [IW-1:0]       r_owner;
  logic [LenWidth-1:0] r_len;
  logic [LenWidth-1:0] r_beats;
  logic                r_mh;

  logic          w_onehot;
  logic          w_multi;
  logic [IW-1:0] w_idx;
  logic          w_busy;
  logic          w_lost;
  logic          w_accept;
  logic          w_stall;
  logic          w_clr;
  logic          w_expired;

  assign w_onehot = (BAGD != '0) &&
                    ((BAGD & (BAGD - 1'b1)) == '0);
  assign w_multi  = (BAGD != '0) && !w_onehot;
  assign w_idx    = IW'(onehot_to_idx(32'(BAGD)));

  assign w_busy   = (r_state == ADDR) ||
                    (r_state == DATA);
  assign w_lost   = w_busy && !BAGD[r_owner];
  // A lost grant swallows any beat offered with it
  assign w_accept = w_busy && TargetReady && !w_lost;
  assign w_stall  = w_busy && !TargetReady;
  assign w_clr    = (w_next != r_state) || w_accept ||
                    !w_busy;

  bus_watchdog #(
    .TimeoutCycles(TimeoutCycles)
  ) u_wdog (
    .clk    (clk),
    .Reset  (Reset),
    .clr    (w_clr),
    .stall  (w_stall),
    .expired(w_expired)
  );

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE: if (w_onehot) w_next = ADDR;
      ADDR: begin
        if (w_lost || w_expired) w_next = ERR;
        else if (TargetReady)    w_next = DATA;
      end
      DATA: begin
        if (w_lost || w_expired)
          w_next = ERR;
        else if (TargetReady && r_beats == '0)
          w_next = DONE;
      end
      DONE:    w_next = IDLE;
      ERR:     w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (Reset) begin
      r_state <= IDLE;
      r_owner <= '0;
      r_len   <= '0;
      r_beats <= '0;
      r_mh    <= 1'b0;
    end else begin
      r_state <= w_next;
      r_mh    <= (r_state == IDLE) && w_multi;
      if (r_state == IDLE && w_onehot) begin
        r_owner <= w_idx;
        r_len   <= XferLen[w_idx*LenWidth +: LenWidth];
      end
      if (r_state == ADDR && w_next == DATA)
        r_beats <= r_len;
      else if (r_state == DATA && w_accept &&
               r_beats != '0)
        r_beats <= r_beats - 1'b1;
    end
  end

  assign AddressValid = (r_state == ADDR);
  assign DataStrobe   = (r_state == DATA);
  assign Error        = (r_state == ERR) || r_mh;
  assign ActiveDev    = r_owner;

  always_comb begin
    Done = '0;
    if (r_state == DONE || r_state == ERR)
      Done[r_owner] = 1'b1;
  end

endmodule
